// File: rtl/kgp_pkg.sv
// Shared definitions for the KGP-RISC fetch/sequencing path.
package kgp_pkg;

    localparam int unsigned PC_W     = 32;
    localparam int unsigned OFFSET_W = 26;
    localparam int unsigned PC_STEP  = 4;

    localparam logic [PC_W-1:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } pcseq_state_t;

    // Branch target: upper bits zero, low two bits forced to zero so the target is word aligned.
    function automatic logic [PC_W-1:0] branch_target(input logic [OFFSET_W-1:0] offset);
        return {{(PC_W-OFFSET_W){1'b0}}, offset[OFFSET_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Program counter and instruction-fetch sequencer for KGP-RISC.
// Owns the PC, performs a req/ack fetch with instruction memory, holds the
// fetched word while the datapath executes it, and advances the PC on retire.
//
// state   | meaning
// S_IDLE  | one cycle after reset before the first fetch
// S_FETCH | imem_req high at pc, waiting for imem_ack
// S_EXEC  | instr valid and held, waiting for exec_done
// S_HALT  | stopped by a halt instruction, only rst leaves
module pc_sequencer
    import kgp_pkg::*;
#(
    parameter logic [31:0] RESET_PC = kgp_pkg::RESET_PC,
    parameter int unsigned PC_STEP  = kgp_pkg::PC_STEP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch,
    input  logic [25:0] offset,
    input  logic        exec_done,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    output logic        halted,
    output logic [31:0] retired_count
);

    pcseq_state_t      state;
    pcseq_state_t      next_state;
    logic [PC_W-1:0]   pc_seq;
    logic [PC_W-1:0]   pc_next;
    logic              retire;
    logic              offset_lsb_unused;

    // The branch unit may present unaligned offsets; the low bits are dropped by design.
    assign offset_lsb_unused = ^offset[1:0];

    assign pc_seq    = pc + PC_W'(PC_STEP);
    assign link_addr = pc_seq;
    assign imem_addr = pc;
    assign retire    = (state == S_EXEC) && exec_done;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and next-PC selection.
    always_comb begin
        next_state = state;
        pc_next    = pc;
        case (state)
            S_IDLE: begin
                next_state = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    if (halt) begin
                        next_state = S_HALT;
                    end else begin
                        next_state = S_FETCH;
                        pc_next    = branch ? branch_target(offset) : pc_seq;
                    end
                end
            end
            S_HALT: begin
                next_state = S_HALT;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Registered outputs: request/halt flags follow the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_req <= 1'b0;
            halted   <= 1'b0;
        end else begin
            imem_req <= (next_state == S_FETCH);
            halted   <= (next_state == S_HALT);
        end
    end

    // PC update on retire; halt leaves pc_next equal to pc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (retire) begin
            pc <= pc_next;
        end
    end

    // Instruction latch and its valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr       <= '0;
            instr_valid <= 1'b0;
        end else if ((state == S_FETCH) && imem_ack) begin
            instr       <= imem_data;
            instr_valid <= 1'b1;
        end else if (retire) begin
            instr_valid <= 1'b0;
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_count <= '0;
        end else if (retire) begin
            retired_count <= retired_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer with a behavioural fetch/retire model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        branch = 1'b0;
    logic [25:0] offset = '0;
    logic        exec_done = 1'b0;
    logic        halt = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        halted;
    logic [31:0] retired_count;

    logic        w_rst = 1'b0;
    logic        w_exec_done = 1'b0;
    logic        w_ack = 1'b0;
    logic [31:0] w_data = '0;
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_instr;
    logic        w_valid;
    logic [31:0] w_pc;
    logic [31:0] w_link;
    logic        w_halted;
    logic [31:0] w_count;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
        .clk(clk), .rst(rst), .branch(branch), .offset(offset),
        .exec_done(exec_done), .halt(halt), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .instr(instr), .instr_valid(instr_valid), .pc(pc),
        .link_addr(link_addr), .halted(halted), .retired_count(retired_count)
    );

    pc_sequencer #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_wrap (
        .clk(clk), .rst(w_rst), .branch(1'b0), .offset(26'd0),
        .exec_done(w_exec_done), .halt(1'b0), .imem_req(w_req),
        .imem_addr(w_addr), .imem_ack(w_ack), .imem_data(w_data),
        .instr(w_instr), .instr_valid(w_valid), .pc(w_pc),
        .link_addr(w_link), .halted(w_halted), .retired_count(w_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fetch with 'waits' cycles of no ack; stray exec_done pulses must be ignored.
    task automatic do_fetch(input int waits, input logic [31:0] data);
        for (int i = 0; i < waits; i++) begin
            check("fetch_req_wait", {31'd0, imem_req}, 32'd1);
            check("fetch_addr_wait", imem_addr, m_pc);
            exec_done = 1'($urandom);
            branch    = 1'($urandom);
            halt      = 1'($urandom);
            offset    = 26'($urandom);
            tick();
            exec_done = 1'b0;
            halt      = 1'b0;
            check("fetch_pc_hold", pc, m_pc);
            check("fetch_cnt_hold", retired_count, m_cnt);
            check("fetch_valid_low", {31'd0, instr_valid}, 32'd0);
        end
        check("fetch_req", {31'd0, imem_req}, 32'd1);
        check("fetch_addr", imem_addr, m_pc);
        imem_ack  = 1'b1;
        imem_data = data;
        tick();
        imem_ack  = 1'b0;
        imem_data = $urandom;
        m_instr   = data;
        check("instr", instr, m_instr);
        check("instr_valid", {31'd0, instr_valid}, 32'd1);
        check("req_drop", {31'd0, imem_req}, 32'd0);
    endtask

    // Execute for 'waits' cycles (stray acks ignored), then retire.
    task automatic do_exec(input int waits, input logic br, input logic [25:0] off, input logic hlt);
        for (int i = 0; i < waits; i++) begin
            imem_ack  = 1'($urandom);
            imem_data = $urandom;
            tick();
            imem_ack  = 1'b0;
            check("exec_instr_hold", instr, m_instr);
            check("exec_valid_hold", {31'd0, instr_valid}, 32'd1);
            check("exec_pc_hold", pc, m_pc);
            check("exec_req_low", {31'd0, imem_req}, 32'd0);
        end
        check("link_addr", link_addr, m_pc + 32'd4);
        exec_done = 1'b1;
        branch    = br;
        offset    = off;
        halt      = hlt;
        tick();
        exec_done = 1'b0;
        halt      = 1'b0;
        branch    = 1'($urandom);
        offset    = 26'($urandom);
        m_cnt++;
        if (!hlt) begin
            if (br) m_pc = {6'd0, off} & 32'hFFFF_FFFC;
            else    m_pc = m_pc + 32'd4;
        end
        check("retire_pc", pc, m_pc);
        check("retire_addr", imem_addr, m_pc);
        check("retire_cnt", retired_count, m_cnt);
        check("retire_valid", {31'd0, instr_valid}, 32'd0);
        check("retire_req", {31'd0, imem_req}, {31'd0, !hlt});
        check("retire_halted", {31'd0, halted}, {31'd0, hlt});
    endtask

    initial begin
        m_pc = 32'd0; m_cnt = 32'd0; m_instr = 32'd0;
        #2;
        rst = 1'b1;
        w_rst = 1'b1;
        tick();
        tick();
        check("rst_pc", pc, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_cnt", retired_count, 32'd0);
        rst = 1'b0;
        check("idle_req", {31'd0, imem_req}, 32'd0);
        tick();
        check("first_req", {31'd0, imem_req}, 32'd1);

        do_fetch(2, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            do_exec(i, 1'b0, 26'($urandom), 1'b0);
            do_fetch(i, $urandom);
        end
        check("seq_pc", pc, 32'd12);
        check("seq_cnt", retired_count, 32'd3);
        check("pre_branch_link", link_addr, 32'd16);
        do_exec(1, 1'b1, 26'h000_0103, 1'b0);
        check("branch_addr", imem_addr, 32'h0000_0100);

        for (int n = 0; n < 40; n++) begin
            do_fetch($urandom_range(0, 3), $urandom);
            do_exec($urandom_range(0, 3), 1'($urandom), 26'($urandom), 1'b0);
        end

        // Async reset while a fetch is outstanding.
        check("pre_rst_req", {31'd0, imem_req}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("arst_req", {31'd0, imem_req}, 32'd0);
        check("arst_valid", {31'd0, instr_valid}, 32'd0);
        check("arst_cnt", retired_count, 32'd0);
        check("arst_pc", pc, 32'd0);
        imem_ack = 1'b1;
        imem_data = 32'h1234_5678;
        tick();
        imem_ack = 1'b0;
        rst = 1'b0;
        m_pc = 32'd0; m_cnt = 32'd0;
        check("arst_instr_ignored", instr, 32'd0);
        tick();
        check("rearm_req", {31'd0, imem_req}, 32'd1);
        do_fetch(1, 32'hCAFE_F00D);
        do_exec(0, 1'b0, 26'd0, 1'b0);
        do_fetch(0, 32'h0BAD_C0DE);

        // Halt wins over branch; afterwards everything is inert.
        do_exec(2, 1'b1, 26'h3FF_FFFF, 1'b1);
        for (int i = 0; i < 4; i++) begin
            imem_ack  = 1'b1;
            exec_done = 1'b1;
            branch    = 1'b1;
            offset    = 26'($urandom);
            tick();
            imem_ack  = 1'b0;
            exec_done = 1'b0;
            check("halt_req", {31'd0, imem_req}, 32'd0);
            check("halt_flag", {31'd0, halted}, 32'd1);
            check("halt_pc", pc, m_pc);
            check("halt_cnt", retired_count, m_cnt);
            check("halt_valid", {31'd0, instr_valid}, 32'd0);
        end

        // Wrap-around from the last word of the address space.
        w_rst = 1'b0;
        tick();
        check("wrap_req", {31'd0, w_req}, 32'd1);
        check("wrap_addr", w_addr, 32'hFFFF_FFFC);
        check("wrap_link", w_link, 32'h0000_0000);
        w_ack = 1'b1;
        w_data = 32'h5555_AAAA;
        tick();
        w_ack = 1'b0;
        check("wrap_instr", w_instr, 32'h5555_AAAA);
        w_exec_done = 1'b1;
        tick();
        w_exec_done = 1'b0;
        check("wrap_pc", w_pc, 32'h0000_0000);
        check("wrap_req2", {31'd0, w_req}, 32'd1);
        check("wrap_cnt", w_count, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
